// File: rtl/apb_chip_ctrl_regs.sv
// Chip-control APB4 register file: pad muxing, FLL bypass, scratch and a clock-divider valid/ack handshake.
// Optional privilege checking of writes is enabled by defining CHIP_CTRL_PRIV_CHECK_EN.
module apb_chip_ctrl_regs #(
    parameter int NUM_PADS       = 48,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             paddr_i,
    input  logic [2:0]              pprot_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [31:0]             pwdata_i,
    input  logic [3:0]              pstrb_i,
    output logic [31:0]             prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic [2*NUM_PADS-1:0]   padmux_o,
    output logic                    fll_bypass_o,
    input  logic                    jtag_bypass_i,
    output logic [7:0]              clkdiv_value_o,
    output logic                    clkdiv_valid_o,
    input  logic                    clkdiv_ack_i
);
    localparam int         NUM_PMX    = (NUM_PADS + 15) / 16;
    localparam int         PMX_BITS   = 32 * NUM_PMX;
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0] PMX_BASE   = 10'd4;
    localparam logic [9:0] PMX_END    = 10'(4 + NUM_PMX);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t              state_reg;
    logic [7:0]          count_reg;
    logic [7:0]          pending_div_reg;
    logic [7:0]          commit_div_reg;
    logic                valid_reg;
    logic                status_reg;
    logic [31:0]         scratch_reg;
    logic                fll_reg;
    logic [PMX_BITS-1:0] pmx_flat;

    logic        access;
    logic        idle_access;
    logic        priv_err;
    logic        wr_en;
    logic        start_req;
    logic        mapped;
    logic [9:0]  word;
    logic [31:0] byte_mask;
    logic [31:0] rdata;
    logic        unused_bits;

    assign word        = paddr_i[11:2];
    assign access      = psel_i & penable_i & ~rst_i;
    assign idle_access = access & (state_reg == IDLE);
    assign byte_mask   = {{8{pstrb_i[3]}}, {8{pstrb_i[2]}}, {8{pstrb_i[1]}}, {8{pstrb_i[0]}}};
    assign mapped      = (word < PMX_END);

`ifdef CHIP_CTRL_PRIV_CHECK_EN
    assign priv_err = pwrite_i & ~pprot_i[0];
`else
    assign priv_err = 1'b0;
`endif

    assign wr_en     = idle_access & pwrite_i & ~priv_err;
    assign start_req = wr_en & (word == 10'd2) & pstrb_i[0];

    // Each padmux register masks out fields that map to non-existent pads.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_PMX; gi++) begin : g_pmx
            logic [31:0] field_mask;
            logic [31:0] pmx_reg;
            for (gj = 0; gj < 16; gj++) begin : g_field
                assign field_mask[2*gj +: 2] = (16 * gi + gj < NUM_PADS) ? 2'b11 : 2'b00;
            end
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    pmx_reg <= '0;
                end else if (wr_en && (word == PMX_BASE + 10'(gi))) begin
                    pmx_reg <= (pmx_reg & ~(byte_mask & field_mask))
                             | (pwdata_i & byte_mask & field_mask);
                end
            end
            assign pmx_flat[32*gi +: 32] = pmx_reg;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scratch_reg <= '0;
            fll_reg     <= 1'b0;
        end else if (wr_en) begin
            if (word == 10'd1)
                scratch_reg <= (scratch_reg & ~byte_mask) | (pwdata_i & byte_mask);
            if (word == 10'd3 && pstrb_i[0])
                fll_reg <= pwdata_i[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            pending_div_reg <= 8'd1;
            commit_div_reg  <= 8'd1;
            valid_reg       <= 1'b0;
            status_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_req) begin
                        pending_div_reg <= pwdata_i[7:0];
                        count_reg       <= '0;
                        valid_reg       <= 1'b1;
                        state_reg       <= REQ;
                    end
                end
                REQ: begin
                    count_reg <= count_reg + 8'd1;
                    // An ack in the expiry cycle still commits the new divider.
                    if (clkdiv_ack_i) begin
                        commit_div_reg <= pending_div_reg;
                        status_reg     <= 1'b0;
                        valid_reg      <= 1'b0;
                        state_reg      <= DONE;
                    end else if (count_reg == LAST_COUNT) begin
                        status_reg <= 1'b1;
                        valid_reg  <= 1'b0;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    status_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (word)
            10'd0: rdata = {16'(NUM_PADS), 16'h0001};
            10'd1: rdata = scratch_reg;
            10'd2: rdata = {24'd0, commit_div_reg};
            10'd3: rdata = {30'd0, jtag_bypass_i, fll_reg};
            default: begin
                for (int k = 0; k < NUM_PMX; k++) begin
                    if (word == PMX_BASE + 10'(k))
                        rdata = pmx_flat[32*k +: 32];
                end
            end
        endcase
    end

    assign pready_o       = (idle_access & ~start_req) | (state_reg == DONE);
    assign pslverr_o      = (idle_access & ~start_req & (~mapped | priv_err))
                          | ((state_reg == DONE) & status_reg);
    assign prdata_o       = (idle_access & ~pwrite_i) ? rdata : '0;
    assign padmux_o       = pmx_flat[2*NUM_PADS-1:0];
    assign fll_bypass_o   = fll_reg;
    assign clkdiv_valid_o = valid_reg;
    assign clkdiv_value_o = (state_reg == REQ) ? pending_div_reg : commit_div_reg;
    assign unused_bits    = ^{paddr_i[31:12], paddr_i[1:0], pprot_i, pmx_flat};

endmodule

// File: tb/tb_apb_chip_ctrl_regs.sv
// Bench for apb_chip_ctrl_regs: directed and randomized APB traffic checked against a register-level model.
module tb_apb_chip_ctrl_regs;
    localparam int NUM_PADS = 48;
    localparam int TMO      = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [31:0]           paddr_i;
    logic [2:0]            pprot_i;
    logic                  psel_i, penable_i, pwrite_i;
    logic [31:0]           pwdata_i;
    logic [3:0]            pstrb_i;
    logic [31:0]           prdata_o;
    logic                  pready_o, pslverr_o;
    logic [2*NUM_PADS-1:0] padmux_o;
    logic                  fll_bypass_o;
    logic                  jtag_bypass_i;
    logic [7:0]            clkdiv_value_o;
    logic                  clkdiv_valid_o;
    logic                  clkdiv_ack_i;

    apb_chip_ctrl_regs #(.NUM_PADS(NUM_PADS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .paddr_i(paddr_i), .pprot_i(pprot_i),
        .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
        .pwdata_i(pwdata_i), .pstrb_i(pstrb_i), .prdata_o(prdata_o),
        .pready_o(pready_o), .pslverr_o(pslverr_o), .padmux_o(padmux_o),
        .fll_bypass_o(fll_bypass_o), .jtag_bypass_i(jtag_bypass_i),
        .clkdiv_value_o(clkdiv_value_o), .clkdiv_valid_o(clkdiv_valid_o),
        .clkdiv_ack_i(clkdiv_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // register-level model
    logic [31:0] m_scratch;
    logic [7:0]  m_div;
    logic        m_fll;
    logic [1:0]  m_pad [NUM_PADS];

    // observed / expected results of the last transaction
    logic [31:0] o_rdata, e_rdata;
    logic        o_err, e_err;
    int          o_cyc, e_cyc, o_vcnt, e_vcnt, o_vbad;

    task automatic model_reset();
        m_scratch = '0;
        m_div     = 8'd1;
        m_fll     = 1'b0;
        for (int p = 0; p < NUM_PADS; p++) m_pad[p] = 2'b00;
    endtask

    function automatic logic is_mapped(input logic [9:0] word);
        return word < 10'(4 + (NUM_PADS + 15) / 16);
    endfunction

    function automatic logic [31:0] model_read(input logic [9:0] word);
        logic [31:0] r;
        int pad;
        r = '0;
        if (word == 10'd0) r = {16'(NUM_PADS), 16'h0001};
        else if (word == 10'd1) r = m_scratch;
        else if (word == 10'd2) r = {24'd0, m_div};
        else if (word == 10'd3) r = {30'd0, jtag_bypass_i, m_fll};
        else if (is_mapped(word)) begin
            for (int j = 0; j < 16; j++) begin
                pad = 16 * (int'(word) - 4) + j;
                if (pad < NUM_PADS) r[2*j +: 2] = m_pad[pad];
            end
        end
        return r;
    endfunction

    task automatic model_write(input logic [9:0] word, input logic [31:0] wd, input logic [3:0] strb);
        int pad;
        if (word == 10'd1) begin
            for (int b = 0; b < 4; b++) if (strb[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
        end else if (word == 10'd3) begin
            if (strb[0]) m_fll = wd[0];
        end else if (word >= 10'd4 && is_mapped(word)) begin
            for (int j = 0; j < 16; j++) begin
                pad = 16 * (int'(word) - 4) + j;
                if (pad < NUM_PADS && strb[j/4]) m_pad[pad] = wd[2*j +: 2];
            end
        end
    endtask

    function automatic logic [2*NUM_PADS-1:0] exp_padmux();
        logic [2*NUM_PADS-1:0] v;
        for (int p = 0; p < NUM_PADS; p++) v[2*p +: 2] = m_pad[p];
        return v;
    endfunction

    // Drives one APB transfer; ack_at is the access-cycle index at which ack is pulsed.
    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] strb, input logic [2:0] prot, input int ack_at);
        paddr_i = addr; pwrite_i = wr; pwdata_i = wd; pstrb_i = strb; pprot_i = prot;
        psel_i = 1'b1; penable_i = 1'b0;
        @(negedge clk_i);
        penable_i = 1'b1;
        o_vcnt = 0; o_vbad = 0; o_cyc = -1; o_rdata = '0; o_err = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            clkdiv_ack_i = (n == ack_at);
            #1;
            if (clkdiv_valid_o) begin
                o_vcnt++;
                if (clkdiv_value_o !== wd[7:0]) o_vbad++;
            end
            if (pready_o) begin
                o_cyc = n; o_rdata = prdata_o; o_err = pslverr_o;
                break;
            end
            @(negedge clk_i);
        end
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0; clkdiv_ack_i = 1'b0;
    endtask

    // Runs a transfer, computes its expected response and advances the model.
    task automatic run_txn(input logic [9:0] word, input logic wr, input logic [31:0] wd,
                           input logic [3:0] strb, input logic [2:0] prot, input int ack_at);
        logic [31:0] tmp;
        logic priv_bad, req, ok;
        tmp = $urandom();
`ifdef CHIP_CTRL_PRIV_CHECK_EN
        priv_bad = wr && !prot[0];
`else
        priv_bad = 1'b0;
`endif
        req = wr && (word == 10'd2) && strb[0] && !priv_bad;
        ok = (ack_at >= 1) && (ack_at <= TMO);
        e_rdata = '0; e_cyc = 0; e_vcnt = 0;
        if (!wr) begin
            e_rdata = model_read(word);
            e_err = !is_mapped(word);
        end else if (req) begin
            e_cyc = ok ? ack_at + 1 : TMO + 1;
            e_vcnt = e_cyc - 1;
            e_err = !ok;
        end else begin
            e_err = !is_mapped(word) || priv_bad;
        end
        apb_xfer({tmp[31:12], word, tmp[1:0]}, wr, wd, strb, prot, ack_at);
        if (wr && !req && !priv_bad) model_write(word, wd, strb);
        if (req && ok) m_div = wd[7:0];
        $display("txn word=0x%03h wr=%0d wdata=%08h strb=%b prot=%b ack_at=%0d -> rdata=%08h err=%0d cyc=%0d valid=%0d",
                 word, wr, wd, strb, prot, ack_at, o_rdata, o_err, o_cyc, o_vcnt);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({prdata_o, pready_o, pslverr_o, fll_bypass_o, clkdiv_valid_o} !== 36'd0) begin
            failures++;
            $display("FAIL reset_apb_outs: got %h expected 0", {prdata_o, pready_o, pslverr_o, fll_bypass_o, clkdiv_valid_o});
        end
        checks++;
        if (padmux_o !== '0) begin
            failures++; $display("FAIL reset_padmux: got %h expected 0", padmux_o);
        end
        checks++;
        if (clkdiv_value_o !== 8'd1) begin
            failures++; $display("FAIL reset_clkdiv_value: got %h expected 01", clkdiv_value_o);
        end
        rst_i = 1'b0;
        model_reset();
        for (int w = 0; w < 7; w++) begin
            run_txn(10'(w), 1'b0, '0, 4'h0, 3'b001, -1);
            checks++;
            if (o_rdata !== e_rdata || o_err !== 1'b0 || o_cyc !== 0) begin
                failures++;
                $display("FAIL reset_read word %0d: got %08h err=%0d cyc=%0d expected %08h err=0 cyc=0", w, o_rdata, o_err, o_cyc, e_rdata);
            end
        end
        checks++;
        if (e_rdata !== 32'd0) begin
            failures++; $display("FAIL reset_model_pmx2: got %08h expected 0", e_rdata);
        end
    endtask

    task automatic test_padmux_strobe();
        run_txn(10'd4, 1'b1, 32'hFFFF_FFFF, 4'b0011, 3'b001, -1);
        checks++;
        if (padmux_o[31:0] !== 32'h0000_FFFF || o_err !== 1'b0) begin
            failures++; $display("FAIL padmux0_strb: got %08h err=%0d expected 0000ffff err=0", padmux_o[31:0], o_err);
        end
        run_txn(10'd4, 1'b0, '0, 4'h0, 3'b001, -1);
        checks++;
        if (o_rdata !== 32'h0000_FFFF) begin
            failures++; $display("FAIL padmux0_read: got %08h expected 0000ffff", o_rdata);
        end
        run_txn(10'd6, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001, -1);
        checks++;
        if (padmux_o[95:64] !== 32'hFFFF_FFFF || padmux_o[63:32] !== 32'd0) begin
            failures++; $display("FAIL padmux2_write: got %024h expected ffffffff00000000 in upper words", padmux_o);
        end
        run_txn(10'd7, 1'b0, '0, 4'h0, 3'b001, -1);
        checks++;
        if (o_rdata !== 32'd0 || o_err !== 1'b1) begin
            failures++; $display("FAIL padmux_beyond_pads: got %08h err=%0d expected 0 err=1", o_rdata, o_err);
        end
    endtask

    task automatic test_clkdiv();
        run_txn(10'd2, 1'b1, 32'h0000_0005, 4'hF, 3'b001, 2);
        checks++;
        if (o_vcnt !== 2 || o_cyc !== 3 || o_err !== 1'b0 || o_vbad !== 0) begin
            failures++; $display("FAIL clkdiv_ack: got valid=%0d cyc=%0d err=%0d vbad=%0d expected 2 3 0 0", o_vcnt, o_cyc, o_err, o_vbad);
        end
        run_txn(10'd2, 1'b0, '0, 4'h0, 3'b001, -1);
        checks++;
        if (o_rdata !== 32'd5 || clkdiv_value_o !== 8'd5) begin
            failures++; $display("FAIL clkdiv_readback: got %08h value=%02h expected 5", o_rdata, clkdiv_value_o);
        end
        run_txn(10'd2, 1'b1, 32'h0000_0009, 4'hF, 3'b001, -1);
        checks++;
        if (o_vcnt !== 4 || o_cyc !== 5 || o_err !== 1'b1) begin
            failures++; $display("FAIL clkdiv_timeout: got valid=%0d cyc=%0d err=%0d expected 4 5 1", o_vcnt, o_cyc, o_err);
        end
        run_txn(10'd2, 1'b0, '0, 4'h0, 3'b001, -1);
        checks++;
        if (o_rdata !== 32'd5 || clkdiv_value_o !== 8'd5) begin
            failures++; $display("FAIL clkdiv_timeout_readback: got %08h value=%02h expected 5", o_rdata, clkdiv_value_o);
        end
        // ack pulsed in the same cycle as expiry wins; ack during the IDLE access cycle is ignored
        run_txn(10'd2, 1'b1, 32'h0000_0007, 4'hF, 3'b001, TMO);
        checks++;
        if (o_cyc !== TMO + 1 || o_err !== 1'b0 || clkdiv_value_o !== 8'd7) begin
            failures++; $display("FAIL clkdiv_ack_at_expiry: got cyc=%0d err=%0d value=%02h expected %0d 0 07", o_cyc, o_err, clkdiv_value_o, TMO + 1);
        end
        run_txn(10'd2, 1'b1, 32'h0000_0033, 4'hF, 3'b001, 0);
        checks++;
        if (o_cyc !== TMO + 1 || o_err !== 1'b1 || clkdiv_value_o !== 8'd7) begin
            failures++; $display("FAIL clkdiv_early_ack: got cyc=%0d err=%0d value=%02h expected %0d 1 07", o_cyc, o_err, clkdiv_value_o, TMO + 1);
        end
        run_txn(10'd2, 1'b1, 32'h0000_0044, 4'b1110, 3'b001, 1);
        checks++;
        if (o_cyc !== 0 || o_err !== 1'b0 || o_vcnt !== 0 || clkdiv_value_o !== 8'd7) begin
            failures++; $display("FAIL clkdiv_no_strb: got cyc=%0d err=%0d valid=%0d value=%02h expected 0 0 0 07", o_cyc, o_err, o_vcnt, clkdiv_value_o);
        end
    endtask

    task automatic test_unmapped();
        run_txn(10'h1FF, 1'b0, '0, 4'h0, 3'b001, -1);
        checks++;
        if (o_rdata !== 32'd0 || o_err !== 1'b1 || o_cyc !== 0) begin
            failures++; $display("FAIL unmapped_read: got %08h err=%0d cyc=%0d expected 0 1 0", o_rdata, o_err, o_cyc);
        end
        run_txn(10'h1FF, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001, -1);
        checks++;
        if (o_err !== 1'b1 || padmux_o !== exp_padmux() || fll_bypass_o !== m_fll) begin
            failures++; $display("FAIL unmapped_write: got err=%0d padmux=%024h expected err=1 padmux=%024h", o_err, padmux_o, exp_padmux());
        end
`ifdef CHIP_CTRL_PRIV_CHECK_EN
        run_txn(10'd1, 1'b1, 32'h1234_5678, 4'hF, 3'b000, -1);
        checks++;
        if (o_err !== 1'b1) begin
            failures++; $display("FAIL priv_write_err: got err=%0d expected 1", o_err);
        end
        run_txn(10'd1, 1'b0, '0, 4'h0, 3'b000, -1);
        checks++;
        if (o_rdata !== e_rdata || o_err !== 1'b0) begin
            failures++; $display("FAIL priv_scratch_unchanged: got %08h err=%0d expected %08h err=0", o_rdata, o_err, e_rdata);
        end
`endif
    endtask

    task automatic test_random();
        logic [9:0] word;
        int r;
        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            word = (r < 7) ? 10'(r) : 10'($urandom_range(7, 1023));
            jtag_bypass_i = 1'($urandom_range(0, 1));
            run_txn(word, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), int'($urandom_range(0, 6)));
            checks++;
            if (o_err !== e_err || o_cyc !== e_cyc || o_vcnt !== e_vcnt || o_vbad !== 0) begin
                failures++;
                $display("FAIL rand_resp t=%0d: got err=%0d cyc=%0d valid=%0d vbad=%0d expected err=%0d cyc=%0d valid=%0d",
                         t, o_err, o_cyc, o_vcnt, o_vbad, e_err, e_cyc, e_vcnt);
            end
            checks++;
            if (o_rdata !== e_rdata) begin
                failures++; $display("FAIL rand_rdata t=%0d: got %08h expected %08h", t, o_rdata, e_rdata);
            end
            checks++;
            if (padmux_o !== exp_padmux() || fll_bypass_o !== m_fll || clkdiv_value_o !== m_div || clkdiv_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL rand_state t=%0d: got padmux=%024h fll=%0d div=%02h valid=%0d expected %024h %0d %02h 0",
                         t, padmux_o, fll_bypass_o, clkdiv_value_o, clkdiv_valid_o, exp_padmux(), m_fll, m_div);
            end
        end
    endtask

    task automatic test_reset_mid_req();
        paddr_i = 32'h0000_0008; pwrite_i = 1'b1; pwdata_i = 32'h0000_00AA; pstrb_i = 4'hF;
        pprot_i = 3'b001; psel_i = 1'b1; penable_i = 1'b0; clkdiv_ack_i = 1'b0;
        @(negedge clk_i);
        penable_i = 1'b1;
        @(negedge clk_i);
        #1;
        checks++;
        if (clkdiv_valid_o !== 1'b1 || clkdiv_value_o !== 8'hAA) begin
            failures++; $display("FAIL midreq_in_req: got valid=%0d value=%02h expected 1 aa", clkdiv_valid_o, clkdiv_value_o);
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (clkdiv_valid_o !== 1'b0 || clkdiv_value_o !== 8'd1 || pready_o !== 1'b0 || pslverr_o !== 1'b0
            || padmux_o !== '0 || fll_bypass_o !== 1'b0) begin
            failures++; $display("FAIL midreq_async_reset: got valid=%0d value=%02h pready=%0d pslverr=%0d fll=%0d",
                                 clkdiv_valid_o, clkdiv_value_o, pready_o, pslverr_o, fll_bypass_o);
        end
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        run_txn(10'd2, 1'b0, '0, 4'h0, 3'b001, -1);
        checks++;
        if (o_rdata !== 32'd1 || o_err !== 1'b0 || o_cyc !== 0) begin
            failures++; $display("FAIL midreq_after_reset: got %08h err=%0d cyc=%0d expected 1 0 0", o_rdata, o_err, o_cyc);
        end
        run_txn(10'd1, 1'b0, '0, 4'h0, 3'b001, -1);
        checks++;
        if (o_rdata !== 32'd0) begin
            failures++; $display("FAIL midreq_scratch_reset: got %08h expected 0", o_rdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; paddr_i = '0; pprot_i = 3'b001; psel_i = 1'b0; penable_i = 1'b0;
        pwrite_i = 1'b0; pwdata_i = '0; pstrb_i = 4'h0; jtag_bypass_i = 1'b0; clkdiv_ack_i = 1'b0;
        test_reset();
        test_padmux_strobe();
        test_clkdiv();
        test_unmapped();
        test_random();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
